// File: rtl/exact_match_lookup.sv
// exact_match_lookup: two-way set-associative exact-match table stage.
// Drives the hash unit handshake, then looks up or inserts a key in the
// bucket selected by the folded hash, with per-bucket victim replacement.
module exact_match_lookup #(
   parameter int unsigned KEY_W        = 64,
   parameter int unsigned VAL_W        = 32,
   parameter int unsigned IDX_W        = 8,
   parameter int unsigned HASH_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_op_i,
   input  logic [KEY_W-1:0] req_key_i,
   input  logic [VAL_W-1:0] req_val_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_hit_o,
   output logic [VAL_W-1:0] resp_val_o,
   output logic             resp_evict_o,
   output logic             resp_err_o,
   output logic             hash_start_o,
   output logic [KEY_W-1:0] hash_key_o,
   input  logic             hash_ready_i,
   input  logic [31:0]      hash_val_i
);

   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned CNT_W = $clog2(HASH_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_READ, S_CMP, S_WRITE, S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic               op_q, op_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [VAL_W-1:0]   val_q, val_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_hit_q, resp_hit_d;
   logic [VAL_W-1:0]   resp_val_q, resp_val_d;
   logic               resp_evict_q, resp_evict_d;
   logic               resp_err_q, resp_err_d;
   logic               hash_start_q, hash_start_d;
   logic [DEPTH-1:0]   valid0_q, valid0_d;
   logic [DEPTH-1:0]   valid1_q, valid1_d;
   logic [DEPTH-1:0]   victim_q, victim_d;

   logic [KEY_W-1:0]   key0_mem [DEPTH];
   logic [VAL_W-1:0]   val0_mem [DEPTH];
   logic [KEY_W-1:0]   key1_mem [DEPTH];
   logic [VAL_W-1:0]   val1_mem [DEPTH];
   logic [KEY_W-1:0]   rd_key0_q, rd_key1_q;
   logic [VAL_W-1:0]   rd_val0_q, rd_val1_q;

   logic               we0_c, we1_c;
   logic               hit0_c, hit1_c;
   logic               unused_hash_c;

   assign hit0_c = valid0_q[idx_q] && (rd_key0_q == key_q);
   assign hit1_c = valid1_q[idx_q] && (rd_key1_q == key_q);
   assign unused_hash_c = ^hash_val_i[31:IDX_W];

   // Next-state, response fields and way selection.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      key_d        = key_q;
      val_d        = val_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      resp_hit_d   = resp_hit_q;
      resp_val_d   = resp_val_q;
      resp_evict_d = resp_evict_q;
      resp_err_d   = resp_err_q;
      valid0_d     = valid0_q;
      valid1_d     = valid1_q;
      victim_d     = victim_q;
      we0_c        = 1'b0;
      we1_c        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready_q) begin
               op_d    = req_op_i;
               key_d   = req_key_i;
               val_d   = req_val_i;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (hash_ready_i) begin
               idx_d   = hash_val_i[IDX_W-1:0];
               state_d = S_READ;
            end else if (cnt_q == CNT_W'(HASH_TIMEOUT - 1)) begin
               resp_err_d = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_READ: begin
            state_d = S_CMP;
         end
         S_CMP: begin
            if (!op_q) begin
               resp_hit_d = hit0_c || hit1_c;
               resp_val_d = hit0_c ? rd_val0_q : (hit1_c ? rd_val1_q : '0);
               state_d    = S_RESP;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            resp_hit_d = hit0_c || hit1_c;
            if (hit0_c) begin
               we0_c = 1'b1;
            end else if (hit1_c) begin
               we1_c = 1'b1;
            end else if (!valid0_q[idx_q]) begin
               we0_c = 1'b1;
            end else if (!valid1_q[idx_q]) begin
               we1_c = 1'b1;
            end else begin
               resp_evict_d     = 1'b1;
               we0_c            = !victim_q[idx_q];
               we1_c            = victim_q[idx_q];
               victim_d[idx_q]  = !victim_q[idx_q];
            end
            if (we0_c) valid0_d[idx_q] = 1'b1;
            if (we1_c) valid1_d[idx_q] = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready_i) begin
               resp_hit_d   = 1'b0;
               resp_val_d   = '0;
               resp_evict_d = 1'b0;
               resp_err_d   = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      req_ready_d  = (state_d == S_IDLE);
      resp_valid_d = (state_d == S_RESP);
      hash_start_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
   end

   // State, control and per-bucket flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         op_q         <= 1'b0;
         key_q        <= '0;
         val_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_val_q   <= '0;
         resp_evict_q <= 1'b0;
         resp_err_q   <= 1'b0;
         hash_start_q <= 1'b0;
         valid0_q     <= '0;
         valid1_q     <= '0;
         victim_q     <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         key_q        <= key_d;
         val_q        <= val_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_val_q   <= resp_val_d;
         resp_evict_q <= resp_evict_d;
         resp_err_q   <= resp_err_d;
         hash_start_q <= hash_start_d;
         valid0_q     <= valid0_d;
         valid1_q     <= valid1_d;
         victim_q     <= victim_d;
      end
   end

   // Way RAMs: synchronous read in READ, write in WRITE.
   always_ff @(posedge clk) begin
      if (we0_c) begin
         key0_mem[idx_q] <= key_q;
         val0_mem[idx_q] <= val_q;
      end
      if (we1_c) begin
         key1_mem[idx_q] <= key_q;
         val1_mem[idx_q] <= val_q;
      end
      if (state_q == S_READ) begin
         rd_key0_q <= key0_mem[idx_q];
         rd_val0_q <= val0_mem[idx_q];
         rd_key1_q <= key1_mem[idx_q];
         rd_val1_q <= val1_mem[idx_q];
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_hit_o   = resp_hit_q;
   assign resp_val_o   = resp_val_q;
   assign resp_evict_o = resp_evict_q;
   assign resp_err_o   = resp_err_q;
   assign hash_start_o = hash_start_q;
   assign hash_key_o   = key_q;

endmodule

// File: doc/exact_match_lookup.md
# exact_match_lookup

Two-way set-associative exact-match table stage that sits directly downstream of the `hash` unit. It accepts lookup and insert requests keyed by a 64-bit key and drives the `hash` unit's start/key handshake. It uses the folded hash result as a bucket index, compares the key against both ways of that bucket, and returns hit/value or performs an insert with victim replacement. It is the match stage feeding the action stage of the reconfigurable pipeline.

## Interface
- `KEY_W`, default 64: key width; matches the `hash` key bus.
- `VAL_W`, default 32: stored action value width.
- `IDX_W`, default 8: bucket index width; 2^IDX_W buckets per way.
- `HASH_TIMEOUT`, default 16: maximum cycles spent in HASH_WAIT before an error response.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `req_valid_i` input 1: request valid.
- `req_ready_o` output 1: request accepted when high together with `req_valid_i`.
- `req_op_i` input 1: 0 = lookup, 1 = insert.
- `req_key_i` input KEY_W: key.
- `req_val_i` input VAL_W: value to install (insert only).
- `resp_valid_o` output 1: response valid; held until `resp_ready_i`.
- `resp_ready_i` input 1: response consumed.
- `resp_hit_o` output 1: key was found (lookup) or already present (insert).
- `resp_val_o` output VAL_W: matched value (lookup hit), else 0.
- `resp_evict_o` output 1: insert replaced a valid entry holding a different key.
- `resp_err_o` output 1: hash timeout; all other response fields are 0.
- `hash_start_o` output 1: connects to the hash `start_i` input.
- `hash_key_o` output KEY_W: connects to the hash `key_i` input; holds the latched request key.
- `hash_ready_i` input 1: connects to the hash `hash_ready_o` output.
- `hash_val_i` input 32: connects to the hash `hash_val_o` output; only `[IDX_W-1:0]` is used.

## Operation
- Storage: way0 and way1, each 2^IDX_W entries of {key, val}. Arrays are synchronous-read RAM with 1-cycle read latency.
- Per-bucket flops: valid0, valid1, and a victim bit. All are cleared by reset.
- States and transitions:
  - IDLE: `req_ready_o`=1. On accept, latch op, key and val; go to HASH_ISSUE.
  - HASH_ISSUE: assert `hash_start_o`; ignore `hash_ready_i`, because it can be stale-high from the previous request. Go to HASH_WAIT.
  - HASH_WAIT: keep `hash_start_o`=1 and count cycles.
    - If `hash_ready_i`=1, latch `idx = hash_val_i[IDX_W-1:0]` and go to READ.
    - If the count reaches HASH_TIMEOUT, set err and go to RESP.
  - READ: `hash_start_o`=0; present idx to both ways.
  - COMPARE: hitN = validN && keyN == latched key. Way0 has priority if both match.
    - Lookup: go to RESP with hit and value.
    - Insert: go to WRITE.
  - WRITE: choose the target way:
    - the hit way if there is a hit, else
    - the first invalid way (way0 before way1), else
    - the way named by the victim bit; set evict=1 and toggle the victim bit.
    - Write {key, val} to the target way and set its valid bit. Go to RESP.
  - RESP: `resp_valid_o`=1 with fields stable. On `resp_ready_i`, go to IDLE.
- `hash_start_o` is 0 in every state except HASH_ISSUE and HASH_WAIT. This guarantees start is low for ≥2 cycles between hash requests, which lets the hash unit return to its free state.
- An insert of an existing key overwrites the value, sets hit=1 and evict=0, and leaves the victim bit unchanged.

## Timing
- Reset values: `req_ready_o`=0 while `rst`=0, then 1 in IDLE. `resp_valid_o`, `resp_hit_o`, `resp_evict_o`, `resp_err_o`, and `hash_start_o` are 0. `resp_val_o` and `hash_key_o` are 0. State is IDLE.
- Let the request be accepted at cycle T:
  - HASH_ISSUE is at T+1.
  - Let H be the first HASH_WAIT cycle in which `hash_ready_i`=1.
  - READ is at H+1 and COMPARE at H+2.
  - Lookup: `resp_valid_o` rises at H+3.
  - Insert: WRITE is at H+3 and `resp_valid_o` rises at H+4.
- With the 3-cycle `hash` unit, H = T+4. Lookup response is at T+7; insert response is at T+8.
- Timeout: if ready is never seen, `resp_valid_o` with err=1 appears HASH_TIMEOUT+1 cycles after HASH_ISSUE.
- One request is in flight at a time; `req_ready_o`=0 outside IDLE.
- Back-to-back: the earliest next accept is the cycle after the response handshake.
- `rst` low at any point aborts immediately: state goes to IDLE, outputs and valid/victim flops are cleared, and RAM contents are don't-care.

## Test plan
- Lookup on an empty table for key 0x0102030405060708 (index 0x24) -> response at T+7 with hit=0, val=0, evict=0, err=0.
- Insert key 0x0102030405060708 with val 0xDEADBEEF, then look it up -> insert hit=0, evict=0; lookup hit=1, val=0xDEADBEEF.
- Insert three keys that all hash to index 0x24 (e.g. byte permutations of the same key):
  - 3rd insert -> evict=1 and replaces way0 (victim bit was 0);
  - a lookup of the 1st key -> hit=0;
  - 2nd and 3rd keys -> hit=1.
- Re-insert an existing key with val 0x12345678 -> hit=1, evict=0; a subsequent lookup returns 0x12345678.
- Tie `hash_ready_i` to 0 -> err=1 response after HASH_TIMEOUT+1 cycles; `hash_start_o` drops at RESP.
- Hold `resp_ready_i` low for 5 cycles and then pulse it -> response fields stay stable and `req_ready_o` is 1 the next cycle.
- Assert `rst` low during HASH_WAIT -> all outputs are 0 at once, and a prior insert no longer hits after release.
